mem_write_checker: RTL and testbench

//   Synthesizable verdict monitor downstream of the single-cycle ARM top; snoops the data-memory

---
 rtl/mem_write_checker_pkg.sv | 21 ++
 rtl/mem_write_checker_trace_fifo.sv | 57 +++++
 rtl/mem_write_checker.sv | 137 +++++++++++++
 tb/tb_mem_write_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_checker_pkg.sv
// Shared state encodings and default address/data constants for the mem_write_checker slice.
package mem_write_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mwcState_t;

    localparam logic [31:0] DEFAULT_PASS_ADDR   = 32'd100;
    localparam logic [31:0] DEFAULT_PASS_DATA   = 32'd7;
    localparam logic [31:0] DEFAULT_IGNORE_ADDR = 32'd96;

    // Trace entries keep the address in the upper word so the head splits cleanly.
    function automatic logic [63:0] packTrace(input logic [31:0] adr, input logic [31:0] data);
        return {adr, data};
    endfunction

endpackage

// File: rtl/mem_write_checker_trace_fifo.sv
// mwc_trace_fifo: small synchronous FIFO with wrap-bit pointers, first-word-fall-through head
// and a sticky overflow flag for pushes dropped while full.
module mwc_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         empty,
    output logic [W-1:0] dout,
    output logic         ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;
    logic [W-1:0] mem [DEPTH];
    logic         full;
    logic         doPush;
    logic         doPop;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    assign doPop = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO may still accept the push.
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            ovf   <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !doPush) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Snoops the core's data-memory write bus and latches a pass/fail/timeout verdict in hardware.
// Define TRACE_FIFO_EN to add a trace FIFO of recent stores with readout ports.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DEFAULT_PASS_ADDR,
    parameter logic [31:0] PASS_DATA      = DEFAULT_PASS_DATA,
    parameter logic [31:0] IGNORE_ADDR    = DEFAULT_IGNORE_ADDR,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
`ifdef TRACE_FIFO_EN
    ,
    parameter int          TRACE_DEPTH    = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] write_count,
    output logic [CNT_W-1:0] cycle_count
`ifdef TRACE_FIFO_EN
    ,
    input  logic             trace_pop,
    output logic             trace_valid,
    output logic [31:0]      trace_adr,
    output logic [31:0]      trace_data,
    output logic             trace_ovf
`endif
);

    localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mwcState_t        state;
    mwcState_t        nextState;
    logic [CNT_W-1:0] writeCount;
    logic [CNT_W-1:0] cycleCount;
    logic             isRun;
    logic             isStore;
    logic             passStore;
    logic             failStore;
    logic             timeoutHit;

    assign isRun      = (state == ST_RUN);
    assign isStore    = isRun && MemWrite;
    assign passStore  = isStore && (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
    assign failStore  = isStore && !passStore && (DataAdr != IGNORE_ADDR);
    assign timeoutHit = TIMEOUT_EN && (cycleCount == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Store verdicts take priority over a timeout landing on the same edge.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: nextState = ST_RUN;
            ST_RUN: begin
                if (passStore) begin
                    nextState = ST_PASS;
                end else if (failStore) begin
                    nextState = ST_FAIL;
                end else if (timeoutHit) begin
                    nextState = ST_TIMEOUT;
                end
            end
            default: nextState = state;
        endcase
    end

    // Verdict outputs come straight from flops loaded with the next state's decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
            done    <= 1'b0;
        end else begin
            pass    <= (nextState == ST_PASS);
            fail    <= (nextState == ST_FAIL);
            timeout <= (nextState == ST_TIMEOUT);
            done    <= (nextState == ST_PASS) || (nextState == ST_FAIL) || (nextState == ST_TIMEOUT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeCount <= '0;
            cycleCount <= '0;
        end else if (isRun) begin
            if (cycleCount != '1) begin
                cycleCount <= cycleCount + 1'b1;
            end
            if (MemWrite && (writeCount != '1)) begin
                writeCount <= writeCount + 1'b1;
            end
        end
    end

    assign write_count = writeCount;
    assign cycle_count = cycleCount;

`ifdef TRACE_FIFO_EN
    logic        traceEmpty;
    logic [63:0] traceHead;

    mwc_trace_fifo #(
        .DEPTH(TRACE_DEPTH),
        .W    (64)
    ) uTraceFifo (
        .clk  (clk),
        .reset(reset),
        .push (isStore),
        .pop  (trace_pop),
        .din  (packTrace(DataAdr, WriteData)),
        .empty(traceEmpty),
        .dout (traceHead),
        .ovf  (trace_ovf)
    );

    assign trace_valid = !traceEmpty;
    assign trace_adr   = traceHead[63:32];
    assign trace_data  = traceHead[31:0];
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Randomized and directed bench for mem_write_checker against a behavioural verdict model.
// Trace FIFO checks are compiled in when TRACE_FIFO_EN is defined.
module tb_mem_write_checker;

    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;

    logic        done, pass, fail, timeout;
    logic [15:0] writeCount, cycleCount;
    logic        satDone, satPass, satFail, satTimeout;
    logic [3:0]  satWrite, satCycle;

    int total = 0;
    int bad = 0;

    bit mStarted, mPass, mFail, mTimeout;
    int mWrites, mCycles;

`ifdef TRACE_FIFO_EN
    logic        tracePop = 1'b0;
    logic        traceValid, traceOvf;
    logic [31:0] traceAdr, traceData;
    logic        satTraceValid, satTraceOvf;
    logic [31:0] satTraceAdr, satTraceData;
    logic [63:0] mTrace[$];
    bit          mOvf;
`endif

    always #5 clk = ~clk;

    mem_write_checker #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .write_count(writeCount),
        .cycle_count(cycleCount)
`ifdef TRACE_FIFO_EN
        ,
        .trace_pop  (tracePop),
        .trace_valid(traceValid),
        .trace_adr  (traceAdr),
        .trace_data (traceData),
        .trace_ovf  (traceOvf)
`endif
    );

    // Narrow counters with timeout disabled, used only to observe saturation.
    mem_write_checker #(
        .TIMEOUT_CYCLES(0),
        .CNT_W         (4)
    ) dutSat (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .done       (satDone),
        .pass       (satPass),
        .fail       (satFail),
        .timeout    (satTimeout),
        .write_count(satWrite),
        .cycle_count(satCycle)
`ifdef TRACE_FIFO_EN
        ,
        .trace_pop  (1'b0),
        .trace_valid(satTraceValid),
        .trace_adr  (satTraceAdr),
        .trace_data (satTraceData),
        .trace_ovf  (satTraceOvf)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mStarted = 1'b0;
        mPass    = 1'b0;
        mFail    = 1'b0;
        mTimeout = 1'b0;
        mWrites  = 0;
        mCycles  = 0;
`ifdef TRACE_FIFO_EN
        mTrace.delete();
        mOvf = 1'b0;
`endif
    endtask

    // One clock edge of the checker as described by its rules, not its implementation.
    task automatic modelEdge(input logic we, input logic [31:0] adr, input logic [31:0] data);
        bit running;
        running = mStarted && !(mPass || mFail || mTimeout);
`ifdef TRACE_FIFO_EN
        if (tracePop && mTrace.size() > 0) void'(mTrace.pop_front());
        if (running && we) begin
            if (mTrace.size() < 8) mTrace.push_back({adr, data});
            else mOvf = 1'b1;
        end
`endif
        if (!mStarted) begin
            mStarted = 1'b1;
        end else if (running) begin
            mCycles = (mCycles < 65535) ? mCycles + 1 : 65535;
            if (we) mWrites++;
            if (we && adr == 32'd100 && data == 32'd7) mPass = 1'b1;
            else if (we && adr != 32'd96) mFail = 1'b1;
            else if (mCycles == TIMEOUT) mTimeout = 1'b1;
        end
    endtask

    task automatic checkAll(input string ctx);
        checkOutput({ctx, " done"}, done, mPass || mFail || mTimeout);
        checkOutput({ctx, " pass"}, pass, mPass);
        checkOutput({ctx, " fail"}, fail, mFail);
        checkOutput({ctx, " timeout"}, timeout, mTimeout);
        checkOutput({ctx, " write_count"}, writeCount, mWrites);
        checkOutput({ctx, " cycle_count"}, cycleCount, mCycles);
`ifdef TRACE_FIFO_EN
        checkOutput({ctx, " trace_valid"}, traceValid, mTrace.size() > 0);
        checkOutput({ctx, " trace_ovf"}, traceOvf, mOvf);
        if (mTrace.size() > 0) begin
            checkOutput({ctx, " trace_adr"}, traceAdr, mTrace[0][63:32]);
            checkOutput({ctx, " trace_data"}, traceData, mTrace[0][31:0]);
        end
`endif
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] data,
                                 input string ctx);
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = data;
        @(posedge clk);
        modelEdge(we, adr, data);
        #1;
        checkAll(ctx);
    endtask

    task automatic applyReset(input int cycles);
        MemWrite = 1'b0;
`ifdef TRACE_FIFO_EN
        tracePop = 1'b0;
`endif
        reset = 1'b1;
        modelReset();
        #1;
        checkAll("reset asserted");
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        checkAll("reset released");
    endtask

    initial begin
        logic [31:0] adr, data;
        int          sel, len;

        #2;
        applyReset(2);

        applyStimulus(1'b0, 32'd0, 32'd0, "t1 idle");
        applyStimulus(1'b1, 32'd96, $urandom, "t1 scratch");
        checkOutput("t1 no verdict after scratch", done, 1'b0);
        applyStimulus(1'b1, 32'd100, 32'd7, "t1 pass store");
        checkOutput("t1 pass", pass, 1'b1);
        checkOutput("t1 fail", fail, 1'b0);
        checkOutput("t1 write_count", writeCount, 16'd2);

        applyReset(2);
        applyStimulus(1'b0, 32'd0, 32'd0, "t2 idle");
        applyStimulus(1'b1, 32'd100, 32'd8, "t2 bad data");
        checkOutput("t2 fail", fail, 1'b1);
        applyStimulus(1'b1, 32'd100, 32'd7, "t2 late pass");
        checkOutput("t2 fail sticky", fail, 1'b1);
        checkOutput("t2 pass stays low", pass, 1'b0);
        checkOutput("t2 write_count", writeCount, 16'd1);

        applyReset(2);
        repeat (TIMEOUT) applyStimulus(1'b0, 32'd0, 32'd0, "t3 quiet");
        checkOutput("t3 no timeout yet", timeout, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, "t3 timeout edge");
        checkOutput("t3 timeout", timeout, 1'b1);
        checkOutput("t3 cycle_count", cycleCount, 16'd20);
        repeat (3) applyStimulus(1'b0, 32'd0, 32'd0, "t3 after timeout");
        checkOutput("t3 cycle_count frozen", cycleCount, 16'd20);

        applyReset(2);
        repeat (TIMEOUT) applyStimulus(1'b0, 32'd0, 32'd0, "t4 quiet");
        applyStimulus(1'b1, 32'd100, 32'd7, "t4 pass on timeout edge");
        checkOutput("t4 pass", pass, 1'b1);
        checkOutput("t4 timeout", timeout, 1'b0);

        applyReset(2);
        applyStimulus(1'b0, 32'd0, 32'd0, "t5 idle");
        applyStimulus(1'b1, 32'd96, 32'd1, "t5 store a");
        applyStimulus(1'b1, 32'd96, 32'd2, "t5 store b");
        applyReset(3);
        checkOutput("t5 write_count cleared", writeCount, 16'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, "t5 idle again");
        applyStimulus(1'b1, 32'd100, 32'd7, "t5 fresh pass");
        checkOutput("t5 fresh pass", pass, 1'b1);
        checkOutput("t5 fresh write_count", writeCount, 16'd1);

        applyReset(2);
        repeat (25) applyStimulus(1'b1, 32'd96, 32'hA5, "sat scratch");
        checkOutput("sat write_count", satWrite, 4'hF);
        checkOutput("sat cycle_count", satCycle, 4'hF);
        checkOutput("sat done", satDone, 1'b0);
        checkOutput("sat pass", satPass, 1'b0);
        checkOutput("sat fail", satFail, 1'b0);
        checkOutput("sat timeout", satTimeout, 1'b0);
`ifdef TRACE_FIFO_EN
        checkOutput("sat trace_valid", satTraceValid, 1'b1);
        checkOutput("sat trace_ovf", satTraceOvf, 1'b1);
        checkOutput("sat trace_adr", satTraceAdr, 32'd96);
        checkOutput("sat trace_data", satTraceData, 32'hA5);

        applyReset(2);
        applyStimulus(1'b0, 32'd0, 32'd0, "t6 idle");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'd96, 32'h100 + i, "t6 push");
        checkOutput("t6 trace_ovf", traceOvf, 1'b1);
        checkOutput("t6 head data", traceData, 32'h100);
        for (int i = 0; i < 8; i++) begin
            tracePop = 1'b1;
            applyStimulus(1'b0, 32'd0, 32'd0, "t6 pop");
            checkOutput("t6 trace_valid after pop", traceValid, i < 7);
        end
        applyStimulus(1'b0, 32'd0, 32'd0, "t6 pop empty");
        checkOutput("t6 empty pop valid", traceValid, 1'b0);
        tracePop = 1'b0;
`endif

        for (int run = 0; run < 40; run++) begin
            applyReset(1 + int'($urandom_range(1)));
            len = 5 + int'($urandom_range(24));
            for (int k = 0; k < len; k++) begin
                sel = int'($urandom_range(99));
                adr = (sel < 70) ? 32'd96 : (sel < 85) ? 32'd100 : $urandom;
                data = ($urandom_range(1) == 1) ? 32'd7 : ($urandom % 16);
`ifdef TRACE_FIFO_EN
                tracePop = 1'($urandom_range(1));
`endif
                applyStimulus(1'($urandom_range(3) == 0), adr, data, "random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
